// File: rtl/peak_meas_ctrl.sv
// peak_meas_ctrl: runs detector windows in batches and reports the averaged
// peak-to-peak amplitude and DC midpoint, with a watchdog on detector replies.
module peak_meas_ctrl #(
  parameter int DATA_WIDTH = 18,
  parameter int AVG_LOG2   = 2,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 8000,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  single,
  output logic                  det_start,
  input  logic [DATA_WIDTH-1:0] det_max,
  input  logic [DATA_WIDTH-1:0] det_min,
  input  logic                  det_dready,
  output logic [DATA_WIDTH:0]   vpp,
  output logic [DATA_WIDTH-1:0] offset,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  err_sticky
);
  localparam int AW = DATA_WIDTH + 1 + AVG_LOG2;
  localparam int WW = AVG_LOG2 + 1;
  localparam logic [WW-1:0] LAST_WIN = WW'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST = CNT_WIDTH'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_ACC, S_GAP, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [WW-1:0]           win_q, win_d;
  logic [DATA_WIDTH-1:0]   max_q, max_d, min_q, min_d;
  logic [AW-1:0]           acc_pp_q, acc_pp_d;
  logic signed [AW-1:0]    acc_mid_q, acc_mid_d;
  logic [DATA_WIDTH:0]     vpp_q, vpp_d;
  logic [DATA_WIDTH-1:0]   offset_q, offset_d;
  logic                    rv_q, rv_d, to_q, to_d, err_q, err_d, enable_q;
  logic [DATA_WIDTH:0]     pp;
  logic signed [DATA_WIDTH:0] mid;

  // Both derived from sign-extended operands so full-scale inputs never wrap.
  assign pp  = {max_q[DATA_WIDTH-1], max_q} - {min_q[DATA_WIDTH-1], min_q};
  assign mid = $signed({max_q[DATA_WIDTH-1], max_q}) + $signed({min_q[DATA_WIDTH-1], min_q});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    max_d     = max_q;
    min_d     = min_q;
    acc_pp_d  = acc_pp_q;
    acc_mid_d = acc_mid_q;
    vpp_d     = vpp_q;
    offset_d  = offset_q;
    rv_d      = 1'b0;
    to_d      = 1'b0;
    err_d     = err_q;
    case (state_q)
      S_IDLE: if (single || enable) begin
        state_d   = S_START;
        win_d     = '0;
        acc_pp_d  = '0;
        acc_mid_d = '0;
        err_d     = (single || !enable_q) ? 1'b0 : err_q;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: if (det_dready) begin
        max_d   = det_max;
        min_d   = det_min;
        state_d = S_ACC;
      end else if (cnt_q == TO_LAST) begin
        to_d    = 1'b1;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else cnt_d = cnt_q + CNT_WIDTH'(1);
      S_ACC: begin
        acc_pp_d  = acc_pp_q + AW'(pp);
        acc_mid_d = acc_mid_q + AW'(mid);
        win_d     = win_q + WW'(1);
        cnt_d     = '0;
        state_d   = (win_q == LAST_WIN) ? S_DONE : (GAP_CYCLES == 0) ? S_START : S_GAP;
      end
      S_GAP: if (cnt_q == GAP_LAST) state_d = S_START;
      else cnt_d = cnt_q + CNT_WIDTH'(1);
      S_DONE: begin
        vpp_d    = (DATA_WIDTH+1)'(acc_pp_q >> AVG_LOG2);
        offset_d = DATA_WIDTH'(acc_mid_q >>> (AVG_LOG2 + 1));
        rv_d     = 1'b1;
        if (enable) begin
          acc_pp_d  = '0;
          acc_mid_d = '0;
          win_d     = '0;
          state_d   = S_START;
        end else state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      win_q     <= '0;
      max_q     <= '0;
      min_q     <= '0;
      acc_pp_q  <= '0;
      acc_mid_q <= '0;
      vpp_q     <= '0;
      offset_q  <= '0;
      rv_q      <= 1'b0;
      to_q      <= 1'b0;
      err_q     <= 1'b0;
      enable_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      max_q     <= max_d;
      min_q     <= min_d;
      acc_pp_q  <= acc_pp_d;
      acc_mid_q <= acc_mid_d;
      vpp_q     <= vpp_d;
      offset_q  <= offset_d;
      rv_q      <= rv_d;
      to_q      <= to_d;
      err_q     <= err_d;
      enable_q  <= enable;
    end

  assign det_start    = state_q == S_START;
  assign busy         = state_q != S_IDLE;
  assign vpp          = vpp_q;
  assign offset       = offset_q;
  assign result_valid = rv_q;
  assign timeout_err  = to_q;
  assign err_sticky   = err_q;
endmodule

// File: tb/tb_peak_meas_ctrl.sv
// tb_peak_meas_ctrl: randomized detector model with a batch-averaging reference
// computed from the window values actually delivered.
module tb_peak_meas_ctrl;
  localparam int DW = 18, AL = 2, GAP = 16, TO = 8000, NW = 4;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, single = 1'b0;
  logic det_start, det_dready, result_valid, busy, timeout_err, err_sticky;
  logic [DW-1:0] det_max, det_min, offset;
  logic [DW:0] vpp;
  logic drdy_m = 1'b0, drdy_s = 1'b0;
  logic [DW-1:0] m_max = '0, m_min = '0, s_max = '0, s_min = '0;

  assign det_dready = drdy_m | drdy_s;
  assign det_max = drdy_s ? s_max : m_max;
  assign det_min = drdy_s ? s_min : m_min;

  int checks = 0, failures = 0, cyc = 0;
  int ds_cnt = 0, rv_cnt = 0, to_cnt = 0, fire_cnt = 0, to_cyc = 0;
  int ds_cyc[0:255], rv_cyc[0:255], rv_vpp[0:255], rv_off[0:255];
  int sent_max[0:255], sent_min[0:255], fire_cyc[0:255];
  int plan_max[0:63], plan_min[0:63];
  int plan_wr = 0, plan_rd = 0, det_lat = 3, epoch = 0;
  int last_vpp = 0, last_off = 0;
  bit det_on = 1'b1;

  peak_meas_ctrl #(.DATA_WIDTH(DW), .AVG_LOG2(AL), .GAP_CYCLES(GAP), .TIMEOUT(TO), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .single(single), .det_start(det_start),
    .det_max(det_max), .det_min(det_min), .det_dready(det_dready), .vpp(vpp), .offset(offset),
    .result_valid(result_valid), .busy(busy), .timeout_err(timeout_err), .err_sticky(err_sticky));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (det_start === 1'b1) begin
      ds_cyc[ds_cnt % 256] <= cyc;
      ds_cnt <= ds_cnt + 1;
    end
    if (result_valid === 1'b1) begin
      rv_cyc[rv_cnt % 256] <= cyc;
      rv_vpp[rv_cnt % 256] <= int'(vpp);
      rv_off[rv_cnt % 256] <= int'($signed(offset));
      rv_cnt <= rv_cnt + 1;
    end
    if (timeout_err === 1'b1) begin
      to_cyc <= cyc;
      to_cnt <= to_cnt + 1;
    end
  end

  // Detector: answers each start after det_lat cycles with planned or random values.
  initial begin : det_model
    int ep, a, b, t;
    forever begin
      @(negedge clk);
      if (det_on && det_start === 1'b1) begin
        ep = epoch;
        repeat (det_lat) @(negedge clk);
        if (ep == epoch && rst_n) begin
          if (plan_rd < plan_wr) begin
            a = plan_max[plan_rd % 64];
            b = plan_min[plan_rd % 64];
            plan_rd++;
          end else begin
            a = int'($urandom_range(262143, 0)) - 131072;
            b = int'($urandom_range(262143, 0)) - 131072;
            if (a < b) begin t = a; a = b; b = t; end
          end
          m_max = a[DW-1:0];
          m_min = b[DW-1:0];
          sent_max[fire_cnt % 256] = a;
          sent_min[fire_cnt % 256] = b;
          fire_cyc[fire_cnt % 256] = cyc;
          fire_cnt++;
          drdy_m = 1'b1;
          @(negedge clk);
          drdy_m = 1'b0;
        end
      end
    end
  end

  function automatic int floor_div(longint a, longint b);
    longint q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return int'(q);
  endfunction

  // Reference: mean of (max-min) truncated, and floor of mean of (max+min)/2.
  function automatic void batch_exp(input int base, output int ev, output int eo);
    longint spp = 0, smid = 0;
    for (int i = 0; i < NW; i++) begin
      spp += longint'(sent_max[(base + i) % 256]) - longint'(sent_min[(base + i) % 256]);
      smid += longint'(sent_max[(base + i) % 256]) + longint'(sent_min[(base + i) % 256]);
    end
    ev = int'(spp / NW);
    eo = floor_div(smid, 2 * NW);
  endfunction

  task automatic push_plan(input int a, input int b);
    plan_max[plan_wr % 64] = a;
    plan_min[plan_wr % 64] = b;
    plan_wr++;
  endtask

  task automatic pulse_single;
    @(negedge clk);
    single = 1'b1;
    @(negedge clk);
    single = 1'b0;
  endtask

  task automatic wait_rv(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (rv_cnt >= target) ok = 1'b1;
    end
  endtask

  task automatic wait_fire(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (fire_cnt >= target) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || det_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl busy=%b det_start=%b expected 0 0", busy, det_start);
    end
    checks++;
    if (vpp !== '0 || offset !== '0) begin
      failures++;
      $display("FAIL reset_data vpp=%0d offset=%0d expected 0 0", vpp, offset);
    end
    checks++;
    if (result_valid !== 1'b0 || timeout_err !== 1'b0 || err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags rv=%b to=%b err=%b expected 0 0 0", result_valid, timeout_err, err_sticky);
    end
  endtask

  task automatic test_single_basic;
    int ds0, rv0, f0, bad;
    bit ok;
    det_lat = 3;
    for (int i = 0; i < NW; i++) push_plan(1000, -1000);
    ds0 = ds_cnt; rv0 = rv_cnt; f0 = fire_cnt;
    pulse_single;
    checks++;
    if (det_start !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_start det_start=%b busy=%b expected 1 1", det_start, busy);
    end
    wait_rv(rv0 + 1, 300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_wait result_valid=0 expected 1 within 300 cycles"); end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (ds_cnt - ds0 != NW) begin failures++; $display("FAIL single_starts got=%0d expected %0d", ds_cnt - ds0, NW); end
    bad = 0;
    for (int i = 1; i < NW; i++)
      if (ds_cyc[(ds0 + i) % 256] - ds_cyc[(ds0 + i - 1) % 256] != 2 + GAP + 3) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL start_spacing bad_gaps=%0d expected 0 (spacing %0d)", bad, 2 + GAP + 3); end
    checks++;
    if (rv_cnt - rv0 != 1) begin failures++; $display("FAIL single_rv_count got=%0d expected 1", rv_cnt - rv0); end
    checks++;
    if (rv_vpp[rv0 % 256] != 2000 || rv_off[rv0 % 256] != 0) begin
      failures++;
      $display("FAIL single_result vpp=%0d offset=%0d expected 2000 0", rv_vpp[rv0 % 256], rv_off[rv0 % 256]);
    end
    checks++;
    if (rv_cyc[rv0 % 256] - fire_cyc[(f0 + NW - 1) % 256] != 3) begin
      failures++;
      $display("FAIL result_latency got=%0d expected 3", rv_cyc[rv0 % 256] - fire_cyc[(f0 + NW - 1) % 256]);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_idle busy=%b expected 0", busy); end
  endtask

  task automatic test_vectors;
    int vmx[8] = '{500, 600, 500, 400, 131071, 131071, 131071, 131071};
    int vmn[8] = '{-100, -100, -200, -100, -131072, -131072, -131072, -131072};
    int ev[2] = '{625, 262143};
    int eo[2] = '{187, -1};
    int rv0;
    bit ok;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < NW; i++) push_plan(vmx[c * NW + i], vmn[c * NW + i]);
      rv0 = rv_cnt;
      pulse_single;
      wait_rv(rv0 + 1, 300, ok);
      checks++;
      if (!ok || rv_vpp[rv0 % 256] != ev[c] || rv_off[rv0 % 256] != eo[c]) begin
        failures++;
        $display("FAIL vector%0d ok=%0d vpp=%0d offset=%0d expected %0d %0d", c, ok, rv_vpp[rv0 % 256], rv_off[rv0 % 256], ev[c], eo[c]);
      end
      repeat (2) @(negedge clk);
    end
    last_vpp = ev[1];
    last_off = eo[1];
  endtask

  task automatic test_random;
    int rv0, f0, ev, eo;
    bit ok;
    for (int b = 0; b < 4; b++) begin
      det_lat = int'($urandom_range(6, 1));
      rv0 = rv_cnt; f0 = fire_cnt;
      pulse_single;
      wait_rv(rv0 + 1, 400, ok);
      batch_exp(f0, ev, eo);
      checks++;
      if (!ok || rv_vpp[rv0 % 256] != ev || rv_off[rv0 % 256] != eo || int'($signed(offset)) != eo) begin
        failures++;
        $display("FAIL random%0d ok=%0d vpp=%0d offset=%0d expected %0d %0d", b, ok, rv_vpp[rv0 % 256], rv_off[rv0 % 256], ev, eo);
      end
      last_vpp = ev;
      last_off = eo;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_timeout;
    int ds0, to0, rv0, f0, ev, eo;
    bit ok;
    det_on = 1'b0;
    ds0 = ds_cnt; to0 = to_cnt; rv0 = rv_cnt;
    pulse_single;
    ok = 1'b0;
    for (int i = 0; i < TO + 100 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (to_cnt > to0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL timeout_wait timeout_err=0 expected 1 within %0d cycles", TO + 100); end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (to_cyc - ds_cyc[ds0 % 256] != TO + 1 || to_cnt - to0 != 1) begin
      failures++;
      $display("FAIL timeout_timing delay=%0d pulses=%0d expected %0d 1", to_cyc - ds_cyc[ds0 % 256], to_cnt - to0, TO + 1);
    end
    checks++;
    if (err_sticky !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_state err_sticky=%b busy=%b expected 1 0", err_sticky, busy);
    end
    checks++;
    if (int'(vpp) != last_vpp || int'($signed(offset)) != last_off || rv_cnt != rv0) begin
      failures++;
      $display("FAIL timeout_hold vpp=%0d offset=%0d rv=%0d expected %0d %0d %0d", vpp, $signed(offset), rv_cnt - rv0, last_vpp, last_off, 0);
    end
    det_on = 1'b1;
    det_lat = 2;
    f0 = fire_cnt;
    pulse_single;
    checks++;
    if (err_sticky !== 1'b0) begin failures++; $display("FAIL sticky_clear err_sticky=%b expected 0", err_sticky); end
    wait_rv(rv0 + 1, 300, ok);
    batch_exp(f0, ev, eo);
    checks++;
    if (!ok || rv_vpp[rv0 % 256] != ev || rv_off[rv0 % 256] != eo) begin
      failures++;
      $display("FAIL after_timeout ok=%0d vpp=%0d offset=%0d expected %0d %0d", ok, rv_vpp[rv0 % 256], rv_off[rv0 % 256], ev, eo);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_continuous;
    int rv0, ds0, f0, ev, eo, bad;
    bit ok, ok2, ok3;
    det_lat = int'($urandom_range(4, 1));
    rv0 = rv_cnt; ds0 = ds_cnt; f0 = fire_cnt;
    @(negedge clk);
    enable = 1'b1;
    wait_fire(f0 + 2, 300, ok);
    repeat (3) @(negedge clk);
    s_max = 18'h1FFFF;
    s_min = 18'h20000;
    drdy_s = 1'b1;
    @(negedge clk);
    drdy_s = 1'b0;
    single = 1'b1;
    @(negedge clk);
    single = 1'b0;
    wait_fire(f0 + 13, 1000, ok2);
    @(negedge clk);
    enable = 1'b0;
    wait_rv(rv0 + 4, 500, ok3);
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (!(ok && ok2 && ok3)) begin failures++; $display("FAIL cont_wait got=%0d%0d%0d expected 111", ok, ok2, ok3); end
    checks++;
    if (rv_cnt - rv0 != 4 || ds_cnt - ds0 != 4 * NW || fire_cnt - f0 != 4 * NW || busy !== 1'b0) begin
      failures++;
      $display("FAIL cont_counts rv=%0d starts=%0d windows=%0d busy=%b expected 4 %0d %0d 0", rv_cnt - rv0, ds_cnt - ds0, fire_cnt - f0, busy, 4 * NW, 4 * NW);
    end
    bad = 0;
    for (int b = 0; b < 4; b++) begin
      batch_exp(f0 + b * NW, ev, eo);
      if (rv_vpp[(rv0 + b) % 256] != ev || rv_off[(rv0 + b) % 256] != eo) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL cont_results bad_batches=%0d expected 0", bad); end
  endtask

  task automatic test_reset_mid;
    int rv0, to0, f0, ev, eo;
    bit ok;
    det_lat = 40;
    pulse_single;
    repeat (5) @(negedge clk);
    rv0 = rv_cnt; to0 = to_cnt;
    #2;
    rst_n = 1'b0;
    epoch++;
    #1;
    checks++;
    if (busy !== 1'b0 || det_start !== 1'b0 || vpp !== '0 || offset !== '0) begin
      failures++;
      $display("FAIL async_reset busy=%b det_start=%b vpp=%0d offset=%0d expected 0 0 0 0", busy, det_start, vpp, offset);
    end
    checks++;
    if (result_valid !== 1'b0 || timeout_err !== 1'b0 || err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_flags rv=%b to=%b err=%b expected 0 0 0", result_valid, timeout_err, err_sticky);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    #1;
    checks++;
    if (rv_cnt != rv0 || to_cnt != to0) begin
      failures++;
      $display("FAIL reset_no_pulse rv=%0d to=%0d expected 0 0", rv_cnt - rv0, to_cnt - to0);
    end
    det_lat = 2;
    f0 = fire_cnt;
    pulse_single;
    wait_rv(rv0 + 1, 300, ok);
    batch_exp(f0, ev, eo);
    checks++;
    if (!ok || rv_vpp[rv0 % 256] != ev || rv_off[rv0 % 256] != eo) begin
      failures++;
      $display("FAIL post_reset ok=%0d vpp=%0d offset=%0d expected %0d %0d", ok, rv_vpp[rv0 % 256], rv_off[rv0 % 256], ev, eo);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset;
    test_single_basic;
    test_vectors;
    test_random;
    test_timeout;
    test_continuous;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
